// File: rtl/dds_pkg.sv
// Shared definitions for the DDS configuration bus: frame parser states,
// default sync marker, bus widths and the well-known DDS register addresses.
package dds_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam logic [ADDR_W-1:0] REG_WAVE = 16'h0020;
  localparam logic [ADDR_W-1:0] REG_STEP = 16'h0030;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AH,
    ST_AL,
    ST_DH,
    ST_DL,
    ST_CK,
    ST_WRITE,
    ST_GAP
  } cfg_state_e;

  // States in which a frame is partially received and the inter-byte timer runs.
  function automatic logic in_frame(input cfg_state_e s);
    return (s == ST_AH) || (s == ST_AL) || (s == ST_DH) || (s == ST_DL) || (s == ST_CK);
  endfunction

endpackage

// File: rtl/dds_cfg_timeout.sv
// Inter-byte idle counter. Counts enabled cycles since the last clear and flags
// the cycle in which the idle count reaches TIMEOUT_CYC; shared with status readback.
module dds_cfg_timeout #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at LAST so a stalled enable cannot wrap and re-fire later.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A clear in the expiring cycle wins: the arriving byte cancels the timeout.
  assign expire_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/dds_cfg_master.sv
// Parses SYNC/ADDR_H/ADDR_L/DATA_H/DATA_L/CHK byte frames and issues one
// registered single-cycle register write per valid frame.
// Byte handshake: a byte transfers on a rising edge where rx_valid & rx_ready;
// upstream holds rx_valid/rx_data stable until that edge.
module dds_cfg_master
  import dds_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYC = 1000,
  parameter int         GAP_CYC     = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              wr,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  cfg_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0]        chk_q, chk_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              rdy_q, rdy_d;
  logic              wr_q, wr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic accept;
  logic tmo_expire;

  assign accept = rx_valid && rdy_q;

  dds_cfg_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rstn    (rstn),
    .clr_i   (accept),
    .en_i    (in_frame(state_q)),
    .expire_o(tmo_expire)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    chk_d   = chk_q;
    gap_d   = gap_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    waddr_d = '0;
    wdata_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept && (rx_data == SYNC_BYTE)) begin
          state_d = ST_AH;
          addr_d  = '0;
          data_d  = '0;
          chk_d   = '0;
        end
      end
      ST_AH, ST_AL: begin
        if (accept) begin
          addr_d  = {addr_q[ADDR_W-9:0], rx_data};
          chk_d   = chk_q ^ rx_data;
          state_d = (state_q == ST_AH) ? ST_AL : ST_DH;
        end
      end
      ST_DH, ST_DL: begin
        if (accept) begin
          data_d  = {data_q[DATA_W-9:0], rx_data};
          chk_d   = chk_q ^ rx_data;
          state_d = (state_q == ST_DH) ? ST_DL : ST_CK;
        end
      end
      ST_CK: begin
        if (accept) begin
          if (rx_data == chk_q) begin
            state_d = ST_WRITE;
            wr_d    = 1'b1;
            done_d  = 1'b1;
            waddr_d = addr_q;
            wdata_d = data_q;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        state_d = ST_GAP;
        gap_d   = '0;
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Expiry is only raised in-frame and without an accepted byte.
    if (tmo_expire) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end

    rdy_d = (state_d != ST_WRITE) && (state_d != ST_GAP);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      chk_q   <= '0;
      gap_q   <= '0;
      rdy_q   <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      chk_q   <= chk_d;
      gap_q   <= gap_d;
      rdy_q   <= rdy_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign rx_ready   = rdy_q;
  assign wr         = wr_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_dds_cfg_master.sv
// Bench for dds_cfg_master: directed frame scenarios plus randomized traffic,
// checked cycle by cycle against a frame-level reference model.
`timescale 1ns/1ps
module tb_dds_cfg_master;
  import dds_pkg::*;

  localparam int         T    = 64;
  localparam int         GAP  = 2;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        wr;
  logic [15:0] waddr;
  logic [15:0] wdata;
  logic        frame_done;
  logic        frame_err;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  bit rst_at_edge = 1'b1;
  always @(posedge clk) rst_at_edge = !rstn;

  dds_cfg_master #(
    .SYNC_BYTE  (SYNC),
    .TIMEOUT_CYC(T),
    .GAP_CYC    (GAP)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .wr        (wr),
    .waddr     (waddr),
    .wdata     (wdata),
    .frame_done(frame_done),
    .frame_err (frame_err)
  );

  // ---------------- checking ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Frame level: a SYNC opens a frame, five more bytes complete it, the last
  // byte must equal the XOR of the four payload bytes. A write blocks input
  // for 1+GAP cycles; T idle cycles inside a frame abandon it with an error.
  logic [31:0] exp_q[$];
  logic [7:0]  m_buf[$];
  bit          m_in_frame;
  int          m_idle;
  int          m_gap;
  bit          exp_ready, exp_wr, exp_err;
  logic [15:0] exp_addr, exp_data;

  task automatic model_reset();
    m_in_frame = 0;
    m_buf.delete();
    exp_q.delete();
    m_idle    = 0;
    m_gap     = 0;
    exp_wr    = 0;
    exp_err   = 0;
    exp_addr  = '0;
    exp_data  = '0;
    exp_ready = 1;
  endtask

  task automatic model_step(input bit acc, input logic [7:0] b);
    exp_wr  = 0;
    exp_err = 0;
    if (m_gap > 0) begin
      m_gap--;
    end else if (acc) begin
      m_idle = 0;
      if (!m_in_frame) begin
        if (b == SYNC) begin
          m_in_frame = 1;
          m_buf.delete();
        end
      end else begin
        m_buf.push_back(b);
        if (m_buf.size() == 5) begin
          m_in_frame = 0;
          if ((m_buf[0] ^ m_buf[1] ^ m_buf[2] ^ m_buf[3]) == m_buf[4]) begin
            exp_wr   = 1;
            exp_addr = {m_buf[0], m_buf[1]};
            exp_data = {m_buf[2], m_buf[3]};
            exp_q.push_back({exp_addr, exp_data});
            m_gap = 1 + GAP;
          end else begin
            exp_err = 1;
          end
        end
      end
    end else if (m_in_frame) begin
      m_idle++;
      if (m_idle == T) begin
        exp_err    = 1;
        m_in_frame = 0;
      end
    end
    exp_ready = (m_gap == 0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  int          wr_cnt, err_cnt, low_cnt, nz_cnt;
  logic [31:0] obs_q[$];

  task automatic clear_stats();
    wr_cnt  = 0;
    err_cnt = 0;
    low_cnt = 0;
    nz_cnt  = 0;
    obs_q.delete();
  endtask

  always @(negedge clk) begin
    logic [35:0] got, want;
    logic [63:0] want_wr;
    got = {rx_ready, wr, frame_done, frame_err, waddr, wdata};
    if (!rstn || rst_at_edge) begin
      check("reset_outputs", got, 64'd0);
      model_reset();
    end else begin
      want = {exp_ready, exp_wr, exp_wr, exp_err,
              exp_wr ? exp_addr : 16'h0, exp_wr ? exp_data : 16'h0};
      check("cycle", got, want);
      if (wr) begin
        wr_cnt++;
        obs_q.push_back({waddr, wdata});
        want_wr = '1;
        if (exp_q.size() > 0) want_wr = exp_q.pop_front();
        check("wr_order", {waddr, wdata}, want_wr);
      end
      if (frame_err) err_cnt++;
      if (!rx_ready) low_cnt++;
      if (!wr && (waddr != 0 || wdata != 0)) nz_cnt++;
      model_step(rx_valid && exp_ready, rx_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got      = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rx_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) check("accept_wait", rx_ready, 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_cfg(input logic [15:0] a, input logic [15:0] d,
                          input logic [7:0] chk_flip, input int gap_max);
    logic [7:0] fr[6];
    fr[0] = SYNC;
    fr[1] = a[15:8];
    fr[2] = a[7:0];
    fr[3] = d[15:8];
    fr[4] = d[7:0];
    fr[5] = a[15:8] ^ a[7:0] ^ d[15:8] ^ d[7:0] ^ chk_flip;
    for (int i = 0; i < 6; i++) begin
      send_byte(fr[i]);
      if (gap_max > 0) idle_cycles($urandom_range(0, gap_max));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_stats();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;

    // 1: single phase-step write
    clear_stats();
    send_cfg(REG_STEP, 16'h000F, 8'h00, 0);
    idle_cycles(8);
    check("t1_wr_cnt", wr_cnt, 1);
    check("t1_err_cnt", err_cnt, 0);
    check("t1_write", obs_q.size() > 0 ? obs_q[0] : 32'hFFFF_FFFF, 32'h0030_000F);
    check("t1_ready_low", low_cnt, 1 + GAP);

    // 2: back-to-back frames
    clear_stats();
    send_cfg(REG_WAVE, 16'h0002, 8'h00, 0);
    send_cfg(REG_STEP, 16'h000F, 8'h00, 0);
    idle_cycles(8);
    check("t2_wr_cnt", wr_cnt, 2);
    check("t2_first", obs_q.size() > 0 ? obs_q[0] : 32'hFFFF_FFFF, 32'h0020_0002);
    check("t2_second", obs_q.size() > 1 ? obs_q[1] : 32'hFFFF_FFFF, 32'h0030_000F);
    check("t2_ready_low", low_cnt, 2 * (1 + GAP));

    // 3: bad checksum (3F -> 00), then a good frame
    clear_stats();
    send_cfg(REG_STEP, 16'h000F, 8'h3F, 0);
    idle_cycles(3);
    check("t3_err_after_bad", err_cnt, 1);
    check("t3_no_wr_after_bad", wr_cnt, 0);
    send_cfg(REG_STEP, 16'h000F, 8'h00, 0);
    idle_cycles(8);
    check("t3_wr_cnt", wr_cnt, 1);
    check("t3_err_cnt", err_cnt, 1);

    // 4: garbage before a frame
    clear_stats();
    send_byte(8'h12);
    send_byte(8'h34);
    send_cfg(REG_STEP, 16'h000F, 8'h00, 0);
    idle_cycles(8);
    check("t4_wr_cnt", wr_cnt, 1);
    check("t4_err_cnt", err_cnt, 0);

    // 5a: stall past the timeout
    clear_stats();
    send_byte(SYNC);
    send_byte(8'h00);
    send_byte(8'h30);
    idle_cycles(T + 4);
    check("t5_tmo_err", err_cnt, 1);
    check("t5_tmo_wr", wr_cnt, 0);
    // 5b: byte lands exactly in the expiring cycle
    clear_stats();
    send_byte(SYNC);
    send_byte(8'h00);
    send_byte(8'h30);
    idle_cycles(T - 1);
    send_byte(8'h00);
    send_byte(8'h0F);
    send_byte(8'h3F);
    idle_cycles(8);
    check("t5_edge_err", err_cnt, 0);
    check("t5_edge_wr", wr_cnt, 1);

    // 6: reset after DATA_L, then resend
    clear_stats();
    send_byte(SYNC);
    send_byte(8'h00);
    send_byte(8'h30);
    send_byte(8'h00);
    send_byte(8'h0F);
    rstn = 1'b0;
    #50 rstn = 1'b1;
    @(posedge clk);
    #1;
    send_cfg(REG_STEP, 16'h000F, 8'h00, 0);
    idle_cycles(8);
    check("t6_wr_cnt", wr_cnt, 1);
    check("t6_err_cnt", err_cnt, 0);
    check("t6_bus_zero", nz_cnt, 0);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      logic [15:0] a, d;
      int kind;
      a = 16'($urandom);
      d = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a[15:8] = SYNC;
      if ($urandom_range(0, 3) == 0) d[7:0] = SYNC;
      kind = $urandom_range(0, 3);
      case (kind)
        0: send_cfg(a, d, 8'h00, 2);
        1: send_cfg(a, d, 8'($urandom_range(1, 255)), 1);
        2: begin
          repeat ($urandom_range(1, 3)) send_byte(8'($urandom));
          send_cfg(a, d, 8'h00, 1);
        end
        default: begin
          int k;
          k = $urandom_range(0, 4);
          send_byte(SYNC);
          for (int i = 0; i < k; i++) send_byte(8'($urandom));
          idle_cycles(T - 1 + $urandom_range(0, 2));
          for (int i = k; i < 5; i++) send_byte(8'($urandom));
        end
      endcase
      idle_cycles($urandom_range(0, GAP + 3));
    end

    idle_cycles(10);
    check("exp_q_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
